// File: rtl/vc_router_pkg.sv
// Shared types and helpers for the VC router allocation stages.
package vc_router_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin winner select: first set request at or above ptr,
// wrapping to the lowest set request when nothing sits at or above ptr.
module rr_priority_select #(
    parameter int num_requests = 64,
    parameter int id_width     = 6
) (
    input  logic [num_requests-1:0] request,
    input  logic [id_width-1:0]     ptr,
    input  logic [num_requests-1:0] mask,
    output logic [num_requests-1:0] winner,
    output logic                    any_request
);

    logic [num_requests-1:0] req_eff;
    logic [num_requests-1:0] thermo;
    logic [num_requests-1:0] upper;
    logic [num_requests-1:0] upper_first;
    logic [num_requests-1:0] all_first;

    assign req_eff = request & ~mask;
    assign thermo  = {num_requests{1'b1}} << ptr;
    assign upper   = req_eff & thermo;

    // x & -x isolates the lowest set bit: one priority encoder per half of the wrap.
    assign upper_first = upper & (-upper);
    assign all_first   = req_eff & (-req_eff);

    assign winner      = (|upper) ? upper_first : all_first;
    assign any_request = |req_eff;

endmodule

// File: rtl/vc_rr_arbiter.sv
// Round-robin arbiter with packet-level grant lock and registered one-hot grant.
// Optional registered binary grant index: define VC_RR_ARBITER_GRANT_ID_EN.
//
// state   | meaning
// IDLE    | no grant held; arbitrate from ptr on any request
// GRANTED | grant locked until release or the grantee drops its request
module vc_rr_arbiter
    import vc_router_pkg::*;
#(
    parameter int num_requests = 64,
    parameter int id_width     = clog2(num_requests)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [num_requests-1:0] request,
    input  logic                    grant_release,
    output logic [num_requests-1:0] grant,
    output logic                    grant_valid
`ifdef VC_RR_ARBITER_GRANT_ID_EN
    ,
    output logic [id_width-1:0]     grant_id
`endif
);

    arb_state_t              state;
    logic [id_width-1:0]     ptr;
    logic [id_width-1:0]     grant_idx;
    logic [id_width-1:0]     next_ptr;
    logic [id_width-1:0]     sel_ptr;
    logic [num_requests-1:0] sel_mask;
    logic [num_requests-1:0] winner;
    logic                    any_request;
    logic                    grantee_req;
    logic                    end_grant;
    logic                    load;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < num_requests; i++) begin
            if (grant[i]) grant_idx = id_width'(i);
        end
    end

    assign next_ptr    = (grant_idx == id_width'(num_requests - 1)) ? '0
                                                                    : grant_idx + id_width'(1);
    assign grantee_req = |(grant & request);
    assign end_grant   = (state == GRANTED) && (grant_release || !grantee_req);
    assign load        = (state == IDLE) || end_grant;

    // On an abort the old grantee must not win the re-arbitration.
    assign sel_ptr  = (state == GRANTED) ? next_ptr : ptr;
    assign sel_mask = (state == GRANTED && !grantee_req) ? grant : '0;

    rr_priority_select #(
        .num_requests (num_requests),
        .id_width     (id_width)
    ) u_select (
        .request     (request),
        .ptr         (sel_ptr),
        .mask        (sel_mask),
        .winner      (winner),
        .any_request (any_request)
    );

`ifdef VC_RR_ARBITER_GRANT_ID_EN
    logic [id_width-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < num_requests; i++) begin
            if (winner[i]) win_idx = id_width'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id <= '0;
        end else if (load) begin
            grant_id <= win_idx;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
        end else if (load) begin
            grant       <= winner;
            grant_valid <= any_request;
            state       <= any_request ? GRANTED : IDLE;
            if (state == GRANTED) ptr <= next_ptr;
        end
    end

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Directed bench for vc_rr_arbiter with four requesters.
module tb_vc_rr_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] request = '0;
    logic         grant_release = 1'b0;
    logic [N-1:0] grant;
    logic         grant_valid;
`ifdef VC_RR_ARBITER_GRANT_ID_EN
    logic [W-1:0] grant_id;
`endif

    int errors = 0;
    int checks = 0;

    vc_rr_arbiter #(
        .num_requests (N),
        .id_width     (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .request       (request),
        .grant_release (grant_release),
        .grant         (grant),
        .grant_valid   (grant_valid)
`ifdef VC_RR_ARBITER_GRANT_ID_EN
        ,
        .grant_id      (grant_id)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [N-1:0] g, input logic [W-1:0] p);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_valid"}, 32'(grant_valid), 32'(|g));
        check({tag, "_ptr"}, 32'(dut.ptr), 32'(p));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset takes effect before any clock edge.
        request = 4'($urandom_range(15, 0));
        #1 rst = 1'b1;
        #1;
        expect_state("reset", 4'b0000, 2'd0);
`ifdef VC_RR_ARBITER_GRANT_ID_EN
        check("reset_id", 32'(grant_id), 32'd0);
`endif
        tick();
        tick();
        rst = 1'b0;

        // Basic grant and back-to-back.
        request = 4'b0101;
        tick();
        expect_state("first_grant", 4'b0001, 2'd0);
        grant_release = 1'b1;
        tick();
        expect_state("b2b_grant", 4'b0100, 2'd1);
        request = 4'b0000;
        tick();
        expect_state("release_to_idle", 4'b0000, 2'd3);

        // Wrap-around.
        grant_release = 1'b0;
        request = 4'b1001;
        tick();
        expect_state("wrap_grant", 4'b1000, 2'd3);
        grant_release = 1'b1;
        tick();
        expect_state("wrap_release", 4'b0001, 2'd0);

        // Abort of grantee 0 hands over to requester 1.
        grant_release = 1'b0;
        request = 4'b0010;
        tick();
        expect_state("abort_handover", 4'b0010, 2'd1);

        // Lock: other requests are ignored while the grantee holds.
        request = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("lock_grant", 32'(grant), 32'(4'b0010));
        end

        // Abort with nobody else waiting.
        request = 4'b0000;
        tick();
        expect_state("abort_idle", 4'b0000, 2'd2);

        // Release in IDLE has no effect.
        grant_release = 1'b1;
        tick();
        expect_state("idle_release", 4'b0000, 2'd2);

        // Sole requester wins again after release.
        grant_release = 1'b0;
        request = 4'b0100;
        tick();
        expect_state("sole_grant", 4'b0100, 2'd2);
`ifdef VC_RR_ARBITER_GRANT_ID_EN
        check("sole_id", 32'(grant_id), 32'd2);
`endif
        grant_release = 1'b1;
        tick();
        expect_state("sole_regrant", 4'b0100, 2'd3);
        grant_release = 1'b0;
        tick();
        expect_state("sole_hold", 4'b0100, 2'd3);

        // Async reset between edges, mid-packet.
        #3 rst = 1'b1;
        #1;
        expect_state("async_reset", 4'b0000, 2'd0);
`ifdef VC_RR_ARBITER_GRANT_ID_EN
        check("async_reset_id", 32'(grant_id), 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        expect_state("post_reset", 4'b0100, 2'd0);
`ifdef VC_RR_ARBITER_GRANT_ID_EN
        check("post_reset_id", 32'(grant_id), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
